// File: rtl/pwm_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pwm_scheduler
// Brief    : 16-channel shared-duty PWM with staged config applied at period
//            boundaries (or immediately when idle).
// Revision : 1.0 - initial release
// ============================================================================
module pwm_scheduler #(
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cfg_en_out,
  input  logic [15:0] cfg_en_pwm,
  input  logic [7:0]  cfg_duty,
  input  logic        cfg_valid,
  output logic        cfg_ack,
  output logic [15:0] pwm_out,
  output logic        period_start,
  output logic        pending
);

  localparam int                 c_PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(PRESCALE - 1);
  localparam logic [c_PRE_W-1:0] c_PRE_ONE = c_PRE_W'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         r_state;
  logic [c_PRE_W-1:0] r_presc;
  logic [7:0]         r_cnt;
  logic [15:0]        r_stg_en_out;
  logic [15:0]        r_stg_en_pwm;
  logic [7:0]         r_stg_duty;
  logic [15:0]        r_act_en_out;
  logic [15:0]        r_act_en_pwm;
  logic [7:0]         r_act_duty;
  logic               r_pending;
  logic               r_ack;
  logic               r_period_start;
  logic [15:0]        r_pwm_out;

  logic               w_tick;
  logic               w_boundary;
  logic               w_apply;
  logic [15:0]        w_next_en_out;
  logic               w_next_run;
  logic [15:0]        w_level;

  always_comb begin
    w_tick        = (r_state == S_RUN) && (r_presc == c_PRE_MAX);
    w_boundary    = w_tick && (r_cnt == 8'hFF);
    // Idle applies as soon as something is staged; run waits for the wrap.
    w_apply       = r_pending && ((r_state == S_IDLE) || w_boundary);
    w_next_en_out = w_apply ? r_stg_en_out : r_act_en_out;
    w_next_run    = (w_next_en_out != 16'h0000);
  end

  always_comb begin
    w_level = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      if (!r_act_en_out[i])          w_level[i] = 1'b0;
      else if (!r_act_en_pwm[i])     w_level[i] = 1'b1;
      else if (r_act_duty == 8'hFF)  w_level[i] = 1'b1;
      else if (r_act_duty == 8'h00)  w_level[i] = 1'b0;
      else                           w_level[i] = (r_cnt < r_act_duty);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_en_out <= 16'h0000;
      r_stg_en_pwm <= 16'h0000;
      r_stg_duty   <= 8'h00;
      r_pending    <= 1'b0;
    end else begin
      if (cfg_valid) begin
        r_stg_en_out <= cfg_en_out;
        r_stg_en_pwm <= cfg_en_pwm;
        r_stg_duty   <= cfg_duty;
      end
      // A strobe coinciding with an apply keeps the new values staged.
      if (cfg_valid)    r_pending <= 1'b1;
      else if (w_apply) r_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_en_out   <= 16'h0000;
      r_act_en_pwm   <= 16'h0000;
      r_act_duty     <= 8'h00;
      r_state        <= S_IDLE;
      r_ack          <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      if (w_apply) begin
        r_act_en_out <= r_stg_en_out;
        r_act_en_pwm <= r_stg_en_pwm;
        r_act_duty   <= r_stg_duty;
      end
      r_state        <= w_next_run ? S_RUN : S_IDLE;
      r_ack          <= w_apply;
      r_period_start <= w_next_run && ((r_state == S_IDLE) || w_boundary);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_cnt   <= 8'h00;
    end else if ((r_state == S_IDLE) || !w_next_run) begin
      r_presc <= '0;
      r_cnt   <= 8'h00;
    end else if (w_tick) begin
      r_presc <= '0;
      r_cnt   <= r_cnt + 8'h01;
    end else begin
      r_presc <= r_presc + c_PRE_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pwm_out <= 16'h0000;
    else        r_pwm_out <= w_level;
  end

  assign cfg_ack      = r_ack;
  assign pwm_out      = r_pwm_out;
  assign period_start = r_period_start;
  assign pending      = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_pwm_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_scheduler
// Brief    : Directed self-checking bench for pwm_scheduler (PRESCALE 1 and 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst3_n = 1'b0;
  logic [15:0] cfg_en_out = 16'h0;
  logic [15:0] cfg_en_pwm = 16'h0;
  logic [7:0]  cfg_duty = 8'h0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ack, period_start, pending;
  logic [15:0] pwm_out;
  logic        cfg_ack3, period_start3, pending3;
  logic [15:0] pwm_out3;

  int n_checks = 0;
  int n_fail = 0;
  int acc_hi0, acc_hi3, acc_hi15, acc_tog3, acc_ps, acc_ack, acc_pend;
  int acc3_hi, acc3_ps, acc3_ack;
  logic prev3;
  int steps;

  always #5 clk = ~clk;

  pwm_scheduler #(.PRESCALE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_en_out(cfg_en_out), .cfg_en_pwm(cfg_en_pwm),
    .cfg_duty(cfg_duty), .cfg_valid(cfg_valid), .cfg_ack(cfg_ack),
    .pwm_out(pwm_out), .period_start(period_start), .pending(pending)
  );

  pwm_scheduler #(.PRESCALE(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .cfg_en_out(cfg_en_out), .cfg_en_pwm(cfg_en_pwm),
    .cfg_duty(cfg_duty), .cfg_valid(cfg_valid), .cfg_ack(cfg_ack3),
    .pwm_out(pwm_out3), .period_start(period_start3), .pending(pending3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    acc_hi0 = 0; acc_hi3 = 0; acc_hi15 = 0; acc_tog3 = 0;
    acc_ps = 0; acc_ack = 0; acc_pend = 0;
    acc3_hi = 0; acc3_ps = 0; acc3_ack = 0;
    prev3 = pwm_out[3];
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      acc_hi0  += int'(pwm_out[0]);
      acc_hi3  += int'(pwm_out[3]);
      acc_hi15 += int'(pwm_out[15]);
      acc_tog3 += int'(pwm_out[3] != prev3);
      prev3     = pwm_out[3];
      acc_ps   += int'(period_start);
      acc_ack  += int'(cfg_ack);
      acc_pend += int'(pending);
      acc3_hi  += int'(pwm_out3[0]);
      acc3_ps  += int'(period_start3);
      acc3_ack += int'(cfg_ack3);
    end
  endtask

  task automatic send(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    cfg_en_out = eo; cfg_en_pwm = ep; cfg_duty = d; cfg_valid = 1'b1;
    run(1);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ack(input int budget, output int n);
    n = 0;
    while (!cfg_ack && n < budget) begin
      run(1);
      n++;
    end
  endtask

  initial begin
    clr();
    run(3);
    chk("rst_pwm", 32'(pwm_out), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_ack", 32'(cfg_ack), 32'h0);
    chk("rst_pstart", 32'(period_start), 32'h0);
    rst_n = 1'b1;
    run(2);

    // First config from idle: ack and period_start one cycle after pending.
    send(16'h0001, 16'h0001, 8'd64);
    chk("idle_pending", 32'(pending), 32'h1);
    chk("idle_ack_early", 32'(cfg_ack), 32'h0);
    run(1);
    chk("idle_ack", 32'(cfg_ack), 32'h1);
    chk("idle_pstart", 32'(period_start), 32'h1);
    chk("idle_pend_clr", 32'(pending), 32'h0);
    run(1);
    chk("first_level", 32'(pwm_out), 32'h0001);
    clr();
    run(256);
    chk("duty64_highs", 32'(acc_hi0), 32'd64);
    chk("duty64_pstarts", 32'(acc_ps), 32'd1);

    // Mid-period duty change at pwm_cnt 30; old duty finishes the period.
    run(29);
    send(16'h0001, 16'h0001, 8'd128);
    chk("mid_pending", 32'(pending), 32'h1);
    clr();
    wait_ack(400, steps);
    chk("mid_ack_latency", 32'(steps), 32'd225);
    chk("mid_old_highs", 32'(acc_hi0), 32'd33);
    chk("mid_pend_views", 32'(acc_pend), 32'd224);
    chk("mid_ack_pstart", 32'(period_start), 32'h1);
    chk("mid_ack_pend", 32'(pending), 32'h0);
    run(1);
    chk("mid_new_first", 32'(pwm_out[0]), 32'h1);
    clr();
    run(256);
    chk("duty128_highs", 32'(acc_hi0), 32'd128);

    // Duty extremes: no pulses at all at 0 or 255.
    send(16'h0009, 16'h0009, 8'd0);
    clr();
    wait_ack(400, steps);
    chk("d0_latency", 32'(steps), 32'd254);
    run(1);
    chk("d0_level", 32'(pwm_out[3]), 32'h0);
    clr();
    run(256);
    chk("d0_highs", 32'(acc_hi3), 32'd0);
    chk("d0_toggles", 32'(acc_tog3), 32'd0);
    send(16'h0009, 16'h0009, 8'd255);
    clr();
    wait_ack(400, steps);
    run(1);
    chk("d255_level", 32'(pwm_out[3]), 32'h1);
    clr();
    run(256);
    chk("d255_highs", 32'(acc_hi3), 32'd256);
    chk("d255_toggles", 32'(acc_tog3), 32'd0);

    // Static channel 15, then a strobe landing exactly on the boundary.
    send(16'h8000, 16'h0000, 8'd0);
    run(253);
    chk("pre_bnd_old", 32'(pwm_out), 32'h0009);
    send(16'h0000, 16'h0000, 8'd0);
    chk("bnd_ack", 32'(cfg_ack), 32'h1);
    chk("bnd_pending_kept", 32'(pending), 32'h1);
    chk("bnd_pstart", 32'(period_start), 32'h1);
    run(1);
    chk("static_level", 32'(pwm_out), 32'h8000);
    clr();
    run(254);
    chk("static_highs", 32'(acc_hi15), 32'd254);
    chk("static_pend", 32'(acc_pend), 32'd254);
    run(1);
    chk("off_ack", 32'(cfg_ack), 32'h1);
    chk("off_pend", 32'(pending), 32'h0);
    chk("off_pstart", 32'(period_start), 32'h0);
    run(1);
    chk("off_level", 32'(pwm_out), 32'h0);
    clr();
    run(20);
    chk("idle_quiet", 32'(acc_ack + acc_ps + acc_hi15 + acc_hi0), 32'd0);

    // Restart from idle must begin at pwm_cnt 0.
    send(16'h0001, 16'h0001, 8'd64);
    run(1);
    chk("re_pstart", 32'(period_start), 32'h1);
    run(1);
    chk("re_cnt0", 32'(pwm_out[0]), 32'h1);
    run(63);
    chk("re_cnt63", 32'(pwm_out[0]), 32'h1);
    run(1);
    chk("re_cnt64", 32'(pwm_out[0]), 32'h0);

    // PRESCALE = 3 instance: async reset at pwm_cnt 100 with pending config.
    rst3_n = 1'b1;
    run(2);
    send(16'h0001, 16'h0001, 8'd50);
    run(1);
    chk("p3_ack", 32'(cfg_ack3), 32'h1);
    clr();
    run(300);
    chk("p3_highs", 32'(acc3_hi), 32'd150);
    chk("p3_no_pstart", 32'(acc3_ps), 32'd0);
    send(16'h0003, 16'h0003, 8'd10);
    chk("p3_pending", 32'(pending3), 32'h1);
    #2 rst3_n = 1'b0;
    #1;
    chk("p3_async_pwm", 32'(pwm_out3), 32'h0);
    chk("p3_async_pend", 32'(pending3), 32'h0);
    chk("p3_async_flags", 32'({cfg_ack3, period_start3}), 32'h0);
    @(posedge clk); #1;
    run(2);
    rst3_n = 1'b1;
    clr();
    run(800);
    chk("p3_stays_idle", 32'(acc3_hi + acc3_ack + acc3_ps), 32'd0);
    chk("p3_pend_after", 32'(pending3), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_scheduler.md
PWM_SCHEDULER -- requirements
Module: pwm_scheduler

Interface
REQ-001 SHALL have parameter PRESCALE, default 4, meaning clk cycles per PWM tick (legal range 1..1023).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port cfg_en_out  input  16  requested per-channel output enable.
REQ-005 SHALL have port cfg_en_pwm  input  16  requested per-channel PWM mode (1 = PWM, 0 = static high when enabled).
REQ-006 SHALL have port cfg_duty  input  8  requested shared duty cycle.
REQ-007 SHALL have port cfg_valid  input  1  single-cycle strobe; the cfg_* inputs are valid in this cycle.
REQ-008 SHALL have port cfg_ack  output  1  single-cycle pulse when staged config becomes active.
REQ-009 SHALL have port pwm_out  output  16  channel outputs.
REQ-010 SHALL have port period_start  output  1  single-cycle pulse marking the first tick of each PWM period.
REQ-011 SHALL have port pending  output  1  high while a staged config awaits application.

Function
REQ-012 SHALL contain a prescaler counter 0..PRESCALE-1; tick = prescaler at PRESCALE-1; prescaler wraps to 0 on tick.
REQ-013 SHALL contain an 8-bit period counter pwm_cnt that increments on tick and wraps 255->0; a period is 256 ticks.
REQ-014 SHALL hold staging registers (en_out, en_pwm, duty) and active registers of the same widths.
REQ-015 On cfg_valid, SHALL load staging from cfg_* and set pending next cycle; back-to-back strobes: last one wins.
REQ-016 SHALL implement two states: IDLE (active en_out == 0) and RUN (active en_out != 0).
REQ-017 In IDLE, SHALL hold prescaler and pwm_cnt at 0 and drive pwm_out = 0.
REQ-018 In IDLE with pending = 1, SHALL copy staging to active on the next clk edge, clear pending, and pulse cfg_ack.
REQ-019 In RUN, SHALL apply staging only at a period boundary (tick with pwm_cnt = 255): copy staging to active, clear pending, pulse cfg_ack in the same cycle pwm_cnt wraps to 0.
REQ-020 IDLE->RUN SHALL start with prescaler = 0 and pwm_cnt = 0, and SHALL pulse period_start in the first RUN cycle.
REQ-021 RUN->IDLE (active en_out becomes 0) SHALL zero the counters on the same edge.
REQ-022 SHALL pulse period_start for one cycle each time pwm_cnt becomes 0 in RUN.
REQ-023 Per-channel level: en_out[i] = 0 -> 0; en_pwm[i] = 0 -> 1; otherwise duty = 255 -> 1, duty = 0 -> 0, else (pwm_cnt < duty).
REQ-024 pwm_out SHALL be registered, lagging active state and pwm_cnt by exactly 1 clk.
REQ-025 If cfg_valid coincides with a boundary, the active registers SHALL take the previous staging contents; staging takes the new cfg_* values and pending stays 1.
REQ-026 The duty comparison SHALL be unsigned 8-bit, with no glitch or extra cycle at wrap.

Reset
REQ-027 While rst_n = 0, SHALL immediately clear all counters, staging, active registers, pwm_out, cfg_ack, period_start, and pending to 0; the state is IDLE.
REQ-028 Reset asserted mid-period SHALL discard pending config; after release the block remains in IDLE until a new cfg_valid.

Verification (PRESCALE = 1 unless noted)
REQ-029 Reset, then cfg_valid with en_out = 16'h0001, en_pwm = 16'h0001, duty = 64 -> cfg_ack 1 cycle later; pwm_out[0] is high for 64 of every 256 cycles; period_start pulses every 256 cycles.
REQ-030 In RUN, issue cfg_valid with duty = 128 mid-period -> pending = 1 until the boundary; the old duty completes the period; the new duty starts at pwm_cnt = 0 together with cfg_ack.
REQ-031 Set duty = 0 and then duty = 255 with en_pwm[3] = 1 -> pwm_out[3] is constant 0, then constant 1, with no single-cycle pulses.
REQ-032 Set en_out = 16'h8000 and en_pwm = 0 -> pwm_out = 16'h8000 constant; then set en_out = 0 -> IDLE at the boundary, counters at 0, pwm_out = 0.
REQ-033 Assert cfg_valid on the boundary cycle -> the previous staging is applied; the new values are applied at the next boundary.
REQ-034 Set PRESCALE = 3 and assert rst_n low at pwm_cnt = 100 -> all outputs drop to 0 asynchronously; pending = 0 after release.
